mem_to_fifo: RTL and testbench

MEM_TO_FIFO -- requirements
Module: mem_to_fifo

---
 rtl/mem_to_fifo_pkg.sv | 33 +++
 rtl/mem_to_fifo_if.sv | 47 ++++
 rtl/mem_to_fifo.sv | 171 +++++++++++++++++
 tb/tb_mem_to_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_to_fifo_pkg.sv
// -----------------------------------------------------------------------------
// mem_to_fifo_pkg
// Shared dataflow definitions for the memory replay path (mem_to_fifo) and its
// companion capture path (fifo_to_mem).
//   - Default bus widths for the QDR address, QDR burst data and loop counter.
//   - Replay FSM state encoding.
//   - Constant-foldable ceil(log2) helper used to size counters.
// -----------------------------------------------------------------------------
package mem_to_fifo_pkg;

    localparam int DFLOW_MEM_ADDR_WIDTH     = 19;
    localparam int DFLOW_MEM_DATA_WIDTH     = 144;
    localparam int DFLOW_REPLAY_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } replay_state_e;

    // Smallest width w such that 2**w >= value.
    function automatic int dflow_clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_to_fifo_if.sv
// -----------------------------------------------------------------------------
// mem_to_fifo_if
// Bundles the memory read channel and the downstream FIFO write channel.
//   master : the replay engine (drives read commands and FIFO writes)
//   slave  : the memory controller / FIFO side
// Signals:
//   app_rd_cmd, app_rd_addr   read command strobe and address
//   app_rd_data, app_rd_valid returned read data and its valid strobe
//   fifo_wr_en, fifo_data     downstream FIFO write
//   fifo_nearly_full          downstream FIFO has few free slots left
// -----------------------------------------------------------------------------
interface mem_to_fifo_if
    import mem_to_fifo_pkg::*;
#(
    parameter int ADDR_W = DFLOW_MEM_ADDR_WIDTH,
    parameter int DATA_W = DFLOW_MEM_DATA_WIDTH
);

    logic              app_rd_cmd;
    logic [ADDR_W-1:0] app_rd_addr;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_valid;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_nearly_full;

    modport master (
        output app_rd_cmd,
        output app_rd_addr,
        input  app_rd_data,
        input  app_rd_valid,
        output fifo_wr_en,
        output fifo_data,
        input  fifo_nearly_full
    );

    modport slave (
        input  app_rd_cmd,
        input  app_rd_addr,
        output app_rd_data,
        output app_rd_valid,
        input  fifo_wr_en,
        input  fifo_data,
        output fifo_nearly_full
    );

endinterface

// File: rtl/mem_to_fifo.sv
// -----------------------------------------------------------------------------
// mem_to_fifo
// Replays an address window [dflow_addr_low, dflow_addr_high] of QDR memory
// into a downstream FIFO, replay_count times (0 = forever).
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   cal_done          memory calibrated; reads only issue while high
//   start_replay      level start request; must drop to leave DONE
//   sw_rst            synchronous soft abort back to IDLE
//   dflow_addr_low/high, replay_count   window and loop count, latched at start
//   bus (master)      read command/response channel and FIFO write channel
//   replay_busy       state is not IDLE
//   replay_done       state is DONE
//   loops_done        completed passes over the window (wraps)
// -----------------------------------------------------------------------------
module mem_to_fifo
    import mem_to_fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH    = DFLOW_MEM_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH     = DFLOW_MEM_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH     = DFLOW_MEM_DATA_WIDTH,
    parameter int REPLAY_COUNT_WIDTH = DFLOW_REPLAY_COUNT_WIDTH,
    parameter int MAX_OUTSTANDING    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cal_done,
    input  logic                          start_replay,
    input  logic                          sw_rst,
    input  logic [MEM_ADDR_WIDTH-1:0]     dflow_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]     dflow_addr_high,
    input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
    mem_to_fifo_if.master                 bus,
    output logic                          replay_busy,
    output logic                          replay_done,
    output logic [REPLAY_COUNT_WIDTH-1:0] loops_done
);

    localparam int              OUT_W   = dflow_clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    replay_state_e                 state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0]     low_q, low_d;
    logic [MEM_ADDR_WIDTH-1:0]     high_q, high_d;
    logic [REPLAY_COUNT_WIDTH-1:0] count_q, count_d;
    logic [MEM_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [REPLAY_COUNT_WIDTH-1:0] loops_q, loops_d;
    logic [OUT_W-1:0]              out_q, out_d;
    logic                          wr_en_q, wr_en_d;
    logic [FIFO_DATA_WIDTH-1:0]    data_q, data_d;

    logic                          rd_cmd;
    logic [MEM_DATA_WIDTH-1:0]     rd_data;
    logic [REPLAY_COUNT_WIDTH-1:0] loops_inc;

    assign rd_data   = bus.app_rd_data;
    assign loops_inc = loops_q + REPLAY_COUNT_WIDTH'(1);

    // Next-state logic. A read issues only in READ with calibrated memory,
    // room in the in-flight window and room downstream; the in-flight count
    // bounds how much data can still land in the FIFO after nearly_full.
    // Returned data is forwarded only while a replay is live, so responses
    // still in flight after a soft abort are dropped but still retired.
    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        high_d  = high_q;
        count_d = count_q;
        addr_d  = addr_q;
        loops_d = loops_q;
        out_d   = out_q;
        wr_en_d = 1'b0;
        data_d  = data_q;
        rd_cmd  = 1'b0;

        if (state_q == ST_READ && cal_done && !sw_rst &&
            out_q < OUT_MAX && !bus.fifo_nearly_full) begin
            rd_cmd = 1'b1;
        end

        if (bus.app_rd_valid && !sw_rst &&
            (state_q == ST_READ || state_q == ST_DRAIN)) begin
            wr_en_d = 1'b1;
            data_d  = rd_data;
        end

        // Command and response in the same cycle cancel out.
        case ({rd_cmd, bus.app_rd_valid})
            2'b10: out_d = out_q + OUT_W'(1);
            2'b01: if (out_q != '0) out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                // Wait for stragglers from an aborted run before restarting.
                if (start_replay && cal_done && out_q == '0) begin
                    low_d   = dflow_addr_low;
                    high_d  = dflow_addr_high;
                    count_d = replay_count;
                    addr_d  = dflow_addr_low;
                    loops_d = '0;
                    state_d = (dflow_addr_high < dflow_addr_low) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (rd_cmd) begin
                    if (addr_q == high_q) begin
                        addr_d  = low_q;
                        loops_d = loops_inc;
                        if (count_q != '0 && loops_inc == count_q) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + MEM_ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_replay) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (sw_rst) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            loops_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            low_q   <= '0;
            high_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            loops_q <= '0;
            out_q   <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            high_q  <= high_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            loops_q <= loops_d;
            out_q   <= out_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
        end
    end

    assign bus.app_rd_cmd  = rd_cmd;
    assign bus.app_rd_addr = addr_q;
    assign bus.fifo_wr_en  = wr_en_q;
    assign bus.fifo_data   = data_q;
    assign replay_busy     = (state_q != ST_IDLE);
    assign replay_done     = (state_q == ST_DONE);
    assign loops_done      = loops_q;

endmodule

// File: tb/tb_mem_to_fifo.sv
// -----------------------------------------------------------------------------
// tb_mem_to_fifo
// Directed sequence of replay scenarios with randomized window placement,
// read latency, memory contents and FIFO backpressure. A memory responder
// returns reads in order after a programmable latency; expected command and
// FIFO streams are rebuilt from the window/loop-count arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_to_fifo;
    import mem_to_fifo_pkg::*;

    localparam int AW   = 19;
    localparam int DW   = 64;
    localparam int CW   = 32;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          calDone;
    logic          startReplay;
    logic          swRst;
    logic [AW-1:0] addrLow;
    logic [AW-1:0] addrHigh;
    logic [CW-1:0] replayCount;
    logic          replayBusy;
    logic          replayDone;
    logic [CW-1:0] loopsDone;

    mem_to_fifo_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_to_fifo #(
        .FIFO_DATA_WIDTH   (DW),
        .MEM_ADDR_WIDTH    (AW),
        .MEM_DATA_WIDTH    (DW),
        .REPLAY_COUNT_WIDTH(CW),
        .MAX_OUTSTANDING   (MAXO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cal_done       (calDone),
        .start_replay   (startReplay),
        .sw_rst         (swRst),
        .dflow_addr_low (addrLow),
        .dflow_addr_high(addrHigh),
        .replay_count   (replayCount),
        .bus            (bus),
        .replay_busy    (replayBusy),
        .replay_done    (replayDone),
        .loops_done     (loopsDone)
    );

    // Posedges at 5,15,...; stimulus changes on negedges, sampling at negedge+4.
    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            cmdAddrQ[$];
    logic [DW-1:0] wrDataQ[$];
    int            pendAddrQ[$];
    int            pendDueQ[$];
    int            tbOut = 0;
    int            maxOut = 0;
    int            overIssue = 0;
    int            cycleNo = 0;
    int            latency = 2;
    logic [31:0]   dataSeed = 32'h0;

    // Memory contents as a pure function of address.
    function automatic logic [DW-1:0] memWord(input int a);
        return {dataSeed ^ (32'(a) * 32'h9E3779B1), 32'(a) ^ 32'hA5A5_0000};
    endfunction

    // Memory responder and bus monitor: records every command and FIFO write
    // just before the capturing edge, keeps an in-flight count, and returns
    // each read in order `latency` cycles after its command.
    initial begin
        bus.app_rd_valid = 1'b0;
        bus.app_rd_data  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                pendAddrQ.delete();
                pendDueQ.delete();
                tbOut = 0;
            end else begin
                if (bus.app_rd_cmd) begin
                    if (tbOut >= MAXO) overIssue++;
                    cmdAddrQ.push_back(int'(bus.app_rd_addr));
                    pendAddrQ.push_back(int'(bus.app_rd_addr));
                    pendDueQ.push_back(cycleNo + latency);
                    tbOut++;
                end
                if (bus.app_rd_valid) tbOut--;
                if (tbOut > maxOut) maxOut = tbOut;
                if (bus.fifo_wr_en) wrDataQ.push_back(bus.fifo_data);
            end
            @(posedge clk);
            #1;
            cycleNo++;
            if (!rst && pendDueQ.size() > 0 && pendDueQ[0] <= cycleNo) begin
                bus.app_rd_valid = 1'b1;
                bus.app_rd_data  = memWord(pendAddrQ.pop_front());
                void'(pendDueQ.pop_front());
            end else begin
                bus.app_rd_valid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int low, input int high, input int count);
        @(negedge clk);
        cmdAddrQ.delete();
        wrDataQ.delete();
        addrLow     = AW'(low);
        addrHigh    = AW'(high);
        replayCount = CW'(count);
        startReplay = 1'b1;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int k = 0;
        while (!replayDone && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, " reached done"}, 64'(replayDone), 64'd1);
    endtask

    task automatic waitCmds(input string tag, input int target, input int budget);
        int k = 0;
        while (cmdAddrQ.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, " cmd target"}, 64'(cmdAddrQ.size() >= target), 64'd1);
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int k = 0;
        while (tbOut != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, " drained"}, 64'(tbOut), 64'd0);
    endtask

    task automatic finishReplay(input string tag);
        startReplay = 1'b0;
        waitCycles(2);
        checkOutput({tag, " back to idle"}, 64'(replayBusy), 64'd0);
    endtask

    // Expected stream: count passes over low..high, in address order.
    task automatic checkSequence(input string tag, input int low, input int high,
                                 input int count);
        int expQ[$];
        int n;
        for (int p = 0; p < count; p++)
            for (int a = low; a <= high; a++)
                expQ.push_back(a);
        checkOutput({tag, " cmd total"}, 64'(cmdAddrQ.size()), 64'(expQ.size()));
        checkOutput({tag, " write total"}, 64'(wrDataQ.size()), 64'(expQ.size()));
        n = (cmdAddrQ.size() < expQ.size()) ? cmdAddrQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(cmdAddrQ[i]), 64'(expQ[i]));
        n = (wrDataQ.size() < expQ.size()) ? wrDataQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s data[%0d]", tag, i), wrDataQ[i], memWord(expQ[i]));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " app_rd_cmd"}, 64'(bus.app_rd_cmd), 64'd0);
        checkOutput({tag, " app_rd_addr"}, 64'(bus.app_rd_addr), 64'd0);
        checkOutput({tag, " fifo_wr_en"}, 64'(bus.fifo_wr_en), 64'd0);
        checkOutput({tag, " fifo_data"}, bus.fifo_data, 64'd0);
        checkOutput({tag, " replay_busy"}, 64'(replayBusy), 64'd0);
        checkOutput({tag, " replay_done"}, 64'(replayDone), 64'd0);
        checkOutput({tag, " loops_done"}, 64'(loopsDone), 64'd0);
    endtask

    initial begin
        int low;
        int high;
        int snap;
        int bad;
        int k;

        rst                  = 1'b1;
        calDone              = 1'b0;
        startReplay          = 1'b0;
        swRst                = 1'b0;
        addrLow              = '0;
        addrHigh             = '0;
        replayCount          = '0;
        bus.fifo_nearly_full = 1'b0;
        dataSeed             = $urandom;

        // Reset values, then a clean release with no output activity.
        waitCycles(3);
        checkAllZero("reset");
        rst = 1'b0;
        waitCycles(3);
        checkOutput("post-reset fifo_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        checkOutput("post-reset busy", 64'(replayBusy), 64'd0);
        checkOutput("post-reset cmds", 64'(cmdAddrQ.size()), 64'd0);
        calDone = 1'b1;

        // Basic two-pass replay of 0..3 with fixed 2-cycle latency.
        latency = 2;
        applyStimulus(0, 3, 2);
        waitDone("basic", 200);
        checkSequence("basic", 0, 3, 2);
        checkOutput("basic loops_done", 64'(loopsDone), 64'd2);
        checkOutput("basic busy", 64'(replayBusy), 64'd1);
        finishReplay("basic");

        // Backpressure hold, calibration pause, then random backpressure.
        latency = $urandom_range(2, 5);
        low     = $urandom_range(100, 150);
        high    = low + $urandom_range(20, 40);
        applyStimulus(low, high, 3);
        waitCmds("bp", 10, 100);
        bus.fifo_nearly_full = 1'b1;
        snap = cmdAddrQ.size();
        waitCycles(20);
        checkOutput("bp hold no cmds", 64'(cmdAddrQ.size()), 64'(snap));
        checkOutput("bp hold busy", 64'(replayBusy), 64'd1);
        bus.fifo_nearly_full = 1'b0;
        waitCycles(3);
        calDone = 1'b0;
        snap = cmdAddrQ.size();
        waitCycles(10);
        checkOutput("cal pause no cmds", 64'(cmdAddrQ.size()), 64'(snap));
        checkOutput("cal pause busy", 64'(replayBusy), 64'd1);
        checkOutput("cal pause done", 64'(replayDone), 64'd0);
        calDone = 1'b1;
        k = 0;
        while (!replayDone && k < 3000) begin
            @(negedge clk);
            bus.fifo_nearly_full = ($urandom_range(0, 3) == 0);
            k++;
        end
        bus.fifo_nearly_full = 1'b0;
        checkOutput("bp reached done", 64'(replayDone), 64'd1);
        checkSequence("bp", low, high, 3);
        checkOutput("bp loops_done", 64'(loopsDone), 64'd3);
        finishReplay("bp");

        // Long latency: in-flight window fills to exactly MAXO, never beyond.
        latency   = 30;
        maxOut    = 0;
        overIssue = 0;
        applyStimulus(0, 63, 1);
        waitDone("latency", 3000);
        checkOutput("latency max outstanding", 64'(maxOut), 64'(MAXO));
        checkOutput("latency issue while full", 64'(overIssue), 64'd0);
        checkSequence("latency", 0, 63, 1);
        finishReplay("latency");

        // Soft abort with 5 reads in flight.
        latency = 20;
        applyStimulus(0, 99, 0);
        waitCmds("swrst", 5, 50);
        swRst = 1'b1;
        waitCycles(1);
        swRst = 1'b0;
        checkOutput("swrst idle", 64'(replayBusy), 64'd0);
        checkOutput("swrst loops cleared", 64'(loopsDone), 64'd0);
        checkOutput("swrst addr cleared", 64'(bus.app_rd_addr), 64'd0);
        checkOutput("swrst in flight", 64'(tbOut), 64'd5);
        waitDrain("swrst", 100);
        waitCycles(1);
        checkOutput("swrst start held off", 64'(cmdAddrQ.size()), 64'd5);
        checkOutput("swrst late data dropped", 64'(wrDataQ.size()), 64'd0);
        waitCycles(5);
        checkOutput("swrst restart addr", 64'((cmdAddrQ.size() > 5) ? cmdAddrQ[5] : -1), 64'd0);
        swRst       = 1'b1;
        startReplay = 1'b0;
        waitCycles(1);
        swRst = 1'b0;
        waitDrain("swrst end", 100);

        // Inverted window goes straight to DONE.
        applyStimulus(10, 5, 1);
        waitDone("inverted", 20);
        checkOutput("inverted cmds", 64'(cmdAddrQ.size()), 64'd0);
        checkOutput("inverted loops", 64'(loopsDone), 64'd0);
        finishReplay("inverted");

        // Infinite replay of a single address.
        latency = 3;
        applyStimulus(7, 7, 0);
        waitCycles(40);
        bad = 0;
        foreach (cmdAddrQ[i]) if (cmdAddrQ[i] != 7) bad++;
        checkOutput("single addr others", 64'(bad), 64'd0);
        checkOutput("single addr volume", 64'(cmdAddrQ.size() >= 30), 64'd1);
        checkOutput("single addr loops", 64'(loopsDone), 64'(cmdAddrQ.size()));
        checkOutput("single addr busy", 64'(replayBusy), 64'd1);
        swRst       = 1'b1;
        startReplay = 1'b0;
        waitCycles(1);
        swRst = 1'b0;
        checkOutput("single addr abort idle", 64'(replayBusy), 64'd0);
        checkOutput("single addr abort loops", 64'(loopsDone), 64'd0);
        waitDrain("single addr", 100);

        // Asynchronous reset while draining.
        latency = 30;
        applyStimulus(0, 15, 1);
        waitCmds("drain", 16, 300);
        waitCycles(2);
        checkOutput("drain busy", 64'(replayBusy), 64'd1);
        checkOutput("drain not done", 64'(replayDone), 64'd0);
        checkOutput("drain loops", 64'(loopsDone), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        @(negedge clk);
        startReplay = 1'b0;
        wrDataQ.delete();
        rst = 1'b0;
        waitCycles(5);
        checkOutput("reset release writes", 64'(wrDataQ.size()), 64'd0);
        checkOutput("reset release busy", 64'(replayBusy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
